// File: rtl/video_route_pkg.sv
// Shared types for the video route scheduler: source encoding, routing
// configuration bundle, FSM state encodings and small routing helpers.
package video_route_pkg;

    typedef logic [2:0] route_src_t;

    // Source encoding. The stage index used by the loop walk reuses these
    // codes: index 0 denotes the output sink, 1..4 the effect stages.
    localparam route_src_t SRC_BASE          = 3'd0;
    localparam route_src_t SRC_CRUSH         = 3'd1;
    localparam route_src_t SRC_DISTORTION    = 3'd2;
    localparam route_src_t SRC_FILTER        = 3'd3;
    localparam route_src_t SRC_REVERB        = 3'd4;
    localparam route_src_t SRC_FIRST_INVALID = 3'd5;

    // Last sink visited by the walk (reverb) and the hop limit per sink.
    localparam route_src_t LAST_SINK = SRC_REVERB;
    localparam logic [2:0] MAX_STEP  = 3'd4;

    typedef struct packed {
        route_src_t output_src;
        route_src_t crush_src;
        route_src_t distortion_src;
        route_src_t filter_src;
        route_src_t reverb_src;
        route_src_t delay_src;
    } route_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_FLUSH
    } route_state_t;

    typedef enum logic [1:0] {
        FL_WAIT_MUTE,
        FL_WAIT_APPLY,
        FL_DRAIN
    } flush_phase_t;

    // Select feeding a given stage (index 0 = output sink).
    function automatic route_src_t stage_src(input route_cfg_t cfg, input route_src_t idx);
        route_src_t src;
        case (idx)
            SRC_BASE:       src = cfg.output_src;
            SRC_CRUSH:      src = cfg.crush_src;
            SRC_DISTORTION: src = cfg.distortion_src;
            SRC_FILTER:     src = cfg.filter_src;
            SRC_REVERB:     src = cfg.reverb_src;
            default:        src = SRC_BASE;
        endcase
        return src;
    endfunction

    // Force the select feeding a stage back to the base source.
    function automatic route_cfg_t clear_stage(input route_cfg_t cfg, input route_src_t idx);
        route_cfg_t res;
        res = cfg;
        case (idx)
            SRC_BASE:       res.output_src     = SRC_BASE;
            SRC_CRUSH:      res.crush_src      = SRC_BASE;
            SRC_DISTORTION: res.distortion_src = SRC_BASE;
            SRC_FILTER:     res.filter_src     = SRC_BASE;
            SRC_REVERB:     res.reverb_src     = SRC_BASE;
            default:        ;
        endcase
        return res;
    endfunction

    // True when two configurations differ in the delay select alone; such a
    // change cannot create a loop and needs no mute.
    function automatic logic only_delay_differs(input route_cfg_t a, input route_cfg_t b);
        return (a.output_src     == b.output_src)     &&
               (a.crush_src      == b.crush_src)      &&
               (a.distortion_src == b.distortion_src) &&
               (a.filter_src     == b.filter_src)     &&
               (a.reverb_src     == b.reverb_src)     &&
               (a.delay_src      != b.delay_src);
    endfunction

endpackage

// File: rtl/route_loop_checker.sv
// Serial routing-graph walker. For every sink (output, crush, distortion,
// filter, reverb) it follows source selects until it reaches the base source,
// failing on an invalid code or a chain longer than four hops (a loop).
// Build option VIDEO_ROUTE_AUTO_REPAIR_EN: instead of failing, the select that
// led to the fault is cleared to base and the walk restarts, up to four times.
module route_loop_checker
    import video_route_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic       start,
    input  route_cfg_t cfg,
    output logic       done,
    output logic       ok
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
    ,
    output route_cfg_t cfg_fixed
`endif
);

    logic       busy_reg,  busy_next;
    route_src_t sink_reg,  sink_next;
    route_src_t cur_reg,   cur_next;
    route_src_t last_reg,  last_next;   // stage whose select produced cur
    logic [2:0] step_reg,  step_next;
    route_cfg_t cfg_reg,   cfg_next;
    logic       done_reg,  done_next;
    logic       ok_reg,    ok_next;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
    localparam logic [2:0] MAX_REPAIRS = 3'd4;
    logic [2:0] repair_reg, repair_next;
    route_cfg_t cfg_repaired;
`endif

    logic fault;
    assign fault = (cur_reg >= SRC_FIRST_INVALID) || (step_reg == MAX_STEP);

`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
    assign cfg_repaired = clear_stage(cfg_reg, last_reg);
`endif

    // Walk registers; everything returns to idle on reset.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            sink_reg   <= SRC_BASE;
            cur_reg    <= SRC_BASE;
            last_reg   <= SRC_BASE;
            step_reg   <= '0;
            cfg_reg    <= '0;
            done_reg   <= 1'b0;
            ok_reg     <= 1'b0;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
            repair_reg <= '0;
`endif
        end else begin
            busy_reg   <= busy_next;
            sink_reg   <= sink_next;
            cur_reg    <= cur_next;
            last_reg   <= last_next;
            step_reg   <= step_next;
            cfg_reg    <= cfg_next;
            done_reg   <= done_next;
            ok_reg     <= ok_next;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
            repair_reg <= repair_next;
`endif
        end
    end

    // One hop per cycle; start always wins so an aborted walk is discarded.
    always_comb begin
        busy_next = busy_reg;
        sink_next = sink_reg;
        cur_next  = cur_reg;
        last_next = last_reg;
        step_next = step_reg;
        cfg_next  = cfg_reg;
        done_next = 1'b0;
        ok_next   = ok_reg;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
        repair_next = repair_reg;
`endif
        if (start) begin
            cfg_next  = cfg;
            sink_next = SRC_BASE;
            cur_next  = cfg.output_src;
            last_next = SRC_BASE;
            step_next = '0;
            busy_next = 1'b1;
            ok_next   = 1'b0;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
            repair_next = '0;
`endif
        end else if (busy_reg) begin
            if (cur_reg == SRC_BASE) begin
                if (sink_reg == LAST_SINK) begin
                    done_next = 1'b1;
                    ok_next   = 1'b1;
                    busy_next = 1'b0;
                end else begin
                    sink_next = sink_reg + 3'd1;
                    cur_next  = stage_src(cfg_reg, sink_reg + 3'd1);
                    last_next = sink_reg + 3'd1;
                    step_next = '0;
                end
            end else if (fault) begin
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
                // Out of repair budget: report failure rather than apply a
                // graph that still cannot be proven loop-free.
                if (repair_reg == MAX_REPAIRS) begin
                    done_next = 1'b1;
                    ok_next   = 1'b0;
                    busy_next = 1'b0;
                end else begin
                    cfg_next    = cfg_repaired;
                    repair_next = repair_reg + 3'd1;
                    sink_next   = SRC_BASE;
                    cur_next    = cfg_repaired.output_src;
                    last_next   = SRC_BASE;
                    step_next   = '0;
                end
`else
                done_next = 1'b1;
                ok_next   = 1'b0;
                busy_next = 1'b0;
`endif
            end else begin
                cur_next  = stage_src(cfg_reg, cur_reg);
                last_next = cur_reg;
                step_next = step_reg + 3'd1;
            end
        end
    end

    assign done = done_reg;
    assign ok   = ok_reg;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
    assign cfg_fixed = cfg_reg;
`endif

endmodule

// File: rtl/video_route_scheduler.sv
// Frame-synchronous routing scheduler. Debounces requested selects over frame
// boundaries, validates the graph with route_loop_checker, mutes video around
// a graph change and swaps the applied selects only on new_frame.
// Build option VIDEO_ROUTE_AUTO_REPAIR_EN: faulty graphs are repaired by the
// checker and applied instead of being rejected.
module video_route_scheduler
    import video_route_pkg::*;
#(
    parameter int STABLE_FRAMES = 1,
    parameter int FLUSH_FRAMES  = 2,
    parameter int SRC_W         = 3   // source encoding is fixed at 3 bits
) (
    input  logic             clk_pixel,
    input  logic             rst,
    input  logic             new_frame,
    input  logic [SRC_W-1:0] req_output_src,
    input  logic [SRC_W-1:0] req_crush_src,
    input  logic [SRC_W-1:0] req_distortion_src,
    input  logic [SRC_W-1:0] req_filter_src,
    input  logic [SRC_W-1:0] req_reverb_src,
    input  logic [SRC_W-1:0] req_delay_src,
    output logic [SRC_W-1:0] app_output_src,
    output logic [SRC_W-1:0] app_crush_src,
    output logic [SRC_W-1:0] app_distortion_src,
    output logic [SRC_W-1:0] app_filter_src,
    output logic [SRC_W-1:0] app_reverb_src,
    output logic [SRC_W-1:0] app_delay_src,
    output logic             video_mute,
    output logic             apply_pulse,
    output logic             cfg_busy,
    output logic             cfg_reject
);

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_FRAMES);
    localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_FRAMES);

    route_state_t state_reg,      state_next;
    flush_phase_t phase_reg,      phase_next;
    logic         delay_only_reg, delay_only_next;
    route_cfg_t   shadow_reg,     shadow_next;
    route_cfg_t   rej_reg,        rej_next;
    route_cfg_t   app_reg,        app_next;
    logic [3:0]   settle_cnt_reg, settle_cnt_next;
    logic [3:0]   frame_cnt_reg,  frame_cnt_next;
    logic         mute_reg,       mute_next;
    logic         apply_reg,      apply_next;
    logic         reject_reg,     reject_next;
    logic         busy_reg,       busy_next;

    route_cfg_t req_cfg;
    logic       req_eq_app, req_eq_shadow, shadow_eq_app, trigger;
    logic       delay_only_now, settle_hit, flush_hit, settle_fire;
    logic       chk_start, chk_done, chk_ok;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
    route_cfg_t chk_cfg_fixed;
`endif

    assign req_cfg.output_src     = req_output_src;
    assign req_cfg.crush_src      = req_crush_src;
    assign req_cfg.distortion_src = req_distortion_src;
    assign req_cfg.filter_src     = req_filter_src;
    assign req_cfg.reverb_src     = req_reverb_src;
    assign req_cfg.delay_src      = req_delay_src;

    assign req_eq_app     = (req_cfg == app_reg);
    assign req_eq_shadow  = (req_cfg == shadow_reg);
    assign shadow_eq_app  = (shadow_reg == app_reg);
    assign trigger        = !req_eq_app && (req_cfg != rej_reg);
    assign delay_only_now = only_delay_differs(shadow_reg, app_reg);
    assign settle_hit     = ((settle_cnt_reg + 4'd1) == STABLE_LAST);
    assign flush_hit      = ((frame_cnt_reg + 4'd1) == FLUSH_LAST);

    // A frame boundary on which the request has been stable long enough.
    assign settle_fire = (state_reg == ST_SETTLE) && req_eq_shadow && !shadow_eq_app &&
                         new_frame && settle_hit;
    assign chk_start   = settle_fire && !delay_only_now;

    route_loop_checker u_checker (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .start     (chk_start),
        .cfg       (shadow_reg),
        .done      (chk_done),
        .ok        (chk_ok)
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
        ,
        .cfg_fixed (chk_cfg_fixed)
`endif
    );

    // State and output registers; reset restores every output immediately.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= FL_WAIT_MUTE;
            delay_only_reg <= 1'b0;
            shadow_reg     <= '0;
            rej_reg        <= '0;
            app_reg        <= '0;
            settle_cnt_reg <= '0;
            frame_cnt_reg  <= '0;
            mute_reg       <= 1'b0;
            apply_reg      <= 1'b0;
            reject_reg     <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            delay_only_reg <= delay_only_next;
            shadow_reg     <= shadow_next;
            rej_reg        <= rej_next;
            app_reg        <= app_next;
            settle_cnt_reg <= settle_cnt_next;
            frame_cnt_reg  <= frame_cnt_next;
            mute_reg       <= mute_next;
            apply_reg      <= apply_next;
            reject_reg     <= reject_next;
            busy_reg       <= busy_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (trigger) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (req_eq_shadow && shadow_eq_app) state_next = ST_IDLE;
                else if (settle_fire)               state_next = delay_only_now ? ST_FLUSH : ST_CHECK;
            end
            ST_CHECK: begin
                if (!req_eq_shadow) state_next = ST_SETTLE;
                else if (chk_done)  state_next = chk_ok ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (new_frame && (delay_only_reg || ((phase_reg == FL_DRAIN) && flush_hit)))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and output updates for the current state.
    always_comb begin
        phase_next      = phase_reg;
        delay_only_next = delay_only_reg;
        shadow_next     = shadow_reg;
        rej_next        = rej_reg;
        app_next        = app_reg;
        settle_cnt_next = settle_cnt_reg;
        frame_cnt_next  = frame_cnt_reg;
        mute_next       = mute_reg;
        apply_next      = 1'b0;
        reject_next     = reject_reg;
        busy_next       = (state_next != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (req_eq_app) reject_next = 1'b0;
                if (trigger) begin
                    shadow_next     = req_cfg;
                    settle_cnt_next = '0;
                end
            end
            ST_SETTLE: begin
                if (!req_eq_shadow) begin
                    shadow_next     = req_cfg;
                    settle_cnt_next = '0;
                end else if (!shadow_eq_app && new_frame) begin
                    settle_cnt_next = settle_cnt_reg + 4'd1;
                    if (settle_hit) begin
                        phase_next      = FL_WAIT_MUTE;
                        delay_only_next = delay_only_now;
                    end
                end
            end
            ST_CHECK: begin
                if (!req_eq_shadow) begin
                    shadow_next     = req_cfg;
                    settle_cnt_next = '0;
                end else if (chk_done) begin
                    if (chk_ok) begin
                        phase_next      = FL_WAIT_MUTE;
                        delay_only_next = 1'b0;
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
                        // Apply the repaired graph; remember the original
                        // request so holding it does not retrigger.
                        shadow_next = chk_cfg_fixed;
                        if (chk_cfg_fixed != shadow_reg) rej_next = shadow_reg;
`endif
                    end else begin
                        reject_next = 1'b1;
                        rej_next    = shadow_reg;
                    end
                end
            end
            ST_FLUSH: begin
                if (new_frame) begin
                    if (delay_only_reg) begin
                        app_next    = shadow_reg;
                        apply_next  = 1'b1;
                        reject_next = 1'b0;
                    end else begin
                        case (phase_reg)
                            FL_WAIT_MUTE: begin
                                mute_next  = 1'b1;
                                phase_next = FL_WAIT_APPLY;
                            end
                            FL_WAIT_APPLY: begin
                                app_next       = shadow_reg;
                                apply_next     = 1'b1;
                                reject_next    = 1'b0;
                                frame_cnt_next = '0;
                                phase_next     = FL_DRAIN;
                            end
                            FL_DRAIN: begin
                                frame_cnt_next = frame_cnt_reg + 4'd1;
                                if (flush_hit) mute_next = 1'b0;
                            end
                            default: phase_next = FL_WAIT_MUTE;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    assign app_output_src     = app_reg.output_src;
    assign app_crush_src      = app_reg.crush_src;
    assign app_distortion_src = app_reg.distortion_src;
    assign app_filter_src     = app_reg.filter_src;
    assign app_reverb_src     = app_reg.reverb_src;
    assign app_delay_src      = app_reg.delay_src;
    assign video_mute         = mute_reg;
    assign apply_pulse        = apply_reg;
    assign cfg_busy           = busy_reg;
    assign cfg_reject         = reject_reg;

endmodule

// File: tb/tb_video_route_scheduler.sv
// Directed bench for video_route_scheduler (STABLE_FRAMES=1, FLUSH_FRAMES=2).
// A vector table drives one frame per record and checks the registered
// outputs one cycle after each new_frame strobe; hand sequences cover the
// reject latency, select toggling and reset during mute.
module tb_video_route_scheduler;

    localparam int GAP = 40;   // idle cycles between frame strobes

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic        new_frame = 1'b0;
    logic [17:0] req_vec = '0;  // {output, crush, distortion, filter, reverb, delay}
    logic [2:0]  req_output_src, req_crush_src, req_distortion_src;
    logic [2:0]  req_filter_src, req_reverb_src, req_delay_src;
    logic [2:0]  app_output_src, app_crush_src, app_distortion_src;
    logic [2:0]  app_filter_src, app_reverb_src, app_delay_src;
    logic        video_mute, apply_pulse, cfg_busy, cfg_reject;
    logic [17:0] app_vec;

    int n_cmp = 0;
    int n_fail = 0;
    int mute_cycles = 0;
    int apply_cycles = 0;

    assign {req_output_src, req_crush_src, req_distortion_src,
            req_filter_src, req_reverb_src, req_delay_src} = req_vec;
    assign app_vec = {app_output_src, app_crush_src, app_distortion_src,
                      app_filter_src, app_reverb_src, app_delay_src};

    always #5 clk_pixel = ~clk_pixel;

    video_route_scheduler #(
        .STABLE_FRAMES (1),
        .FLUSH_FRAMES  (2),
        .SRC_W         (3)
    ) dut (
        .clk_pixel          (clk_pixel),
        .rst                (rst),
        .new_frame          (new_frame),
        .req_output_src     (req_output_src),
        .req_crush_src      (req_crush_src),
        .req_distortion_src (req_distortion_src),
        .req_filter_src     (req_filter_src),
        .req_reverb_src     (req_reverb_src),
        .req_delay_src      (req_delay_src),
        .app_output_src     (app_output_src),
        .app_crush_src      (app_crush_src),
        .app_distortion_src (app_distortion_src),
        .app_filter_src     (app_filter_src),
        .app_reverb_src     (app_reverb_src),
        .app_delay_src      (app_delay_src),
        .video_mute         (video_mute),
        .apply_pulse        (apply_pulse),
        .cfg_busy           (cfg_busy),
        .cfg_reject         (cfg_reject)
    );

    always @(posedge clk_pixel) begin
        if (video_mute)  mute_cycles  <= mute_cycles + 1;
        if (apply_pulse) apply_cycles <= apply_cycles + 1;
    end

    typedef struct {
        string       name;
        logic [17:0] req;
        logic [17:0] app;
        logic        mute;
        logic        apply;
        logic        reject;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [17:0] mk(input logic [2:0] o, input logic [2:0] c, input logic [2:0] d,
                                       input logic [2:0] f, input logic [2:0] r, input logic [2:0] dl);
        return {o, c, d, f, r, dl};
    endfunction

    task automatic add_vec(input string name, input logic [17:0] req, input logic [17:0] app,
                           input logic mute, input logic apply, input logic reject, input logic busy);
        vec_t v;
        v.name = name; v.req = req; v.app = app;
        v.mute = mute; v.apply = apply; v.reject = reject; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic gap();
        repeat (GAP) @(negedge clk_pixel);
    endtask

    // Pulse new_frame for one cycle; returns half a cycle after the edge.
    task automatic strobe();
        new_frame = 1'b1;
        @(negedge clk_pixel);
        new_frame = 1'b0;
    endtask

    task automatic check_all(input string name, input logic [17:0] app, input logic mute,
                             input logic apply, input logic reject, input logic busy);
        check({name, ".app"},    app_vec,     app);
        check({name, ".mute"},   video_mute,  18'(mute));
        check({name, ".apply"},  apply_pulse, 18'(apply));
        check({name, ".reject"}, cfg_reject,  18'(reject));
        check({name, ".busy"},   cfg_busy,    18'(busy));
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            req_vec = vecs[i].req;
            gap();
            strobe();
            check_all(vecs[i].name, vecs[i].app, vecs[i].mute, vecs[i].apply,
                      vecs[i].reject, vecs[i].busy);
            $display("vec %0d %s req=%h app=%h mute=%0b apply=%0b rej=%0b busy=%0b",
                     i, vecs[i].name, vecs[i].req, app_vec, video_mute, apply_pulse,
                     cfg_reject, cfg_busy);
        end
    endtask

    initial begin
        logic [17:0] z, g1, g2, d1, ca, cb, g3;
        int waited;
        int snap_mute, snap_apply;

        z  = '0;
        g1 = mk(4, 0, 0, 0, 1, 0);
        g2 = mk(1, 2, 1, 0, 0, 0);
        d1 = mk(4, 0, 0, 0, 1, 3);
        ca = mk(2, 0, 0, 0, 1, 3);
        cb = mk(3, 0, 0, 0, 1, 3);
        g3 = mk(1, 0, 0, 6, 0, 0);

        // idle and first graph change: records 0..8
        add_vec("idle0",     z,  z,  0, 0, 0, 0);
        add_vec("idle1",     z,  z,  0, 0, 0, 0);
        add_vec("idle2",     z,  z,  0, 0, 0, 0);
        add_vec("g1_settle", g1, z,  0, 0, 0, 1);
        add_vec("g1_mute",   g1, z,  1, 0, 0, 1);
        add_vec("g1_apply",  g1, g1, 1, 1, 0, 1);
        add_vec("g1_drain",  g1, g1, 1, 0, 0, 1);
        add_vec("g1_unmute", g1, g1, 0, 0, 0, 0);
        add_vec("g1_steady", g1, g1, 0, 0, 0, 0);
        // loop reject: records 9..11
        add_vec("g2_settle", g2, g1, 0, 0, 0, 1);
        add_vec("g2_reject", g2, g1, 0, 0, 1, 0);
        add_vec("g2_hold",   g2, g1, 0, 0, 1, 0);
        // delay-only change: records 12..14
        add_vec("d1_settle", d1, g1, 0, 0, 1, 1);
        add_vec("d1_apply",  d1, d1, 0, 1, 0, 0);
        add_vec("d1_steady", d1, d1, 0, 0, 0, 0);
        // invalid filter source: records 15..
        add_vec("g3_settle", g3, z,  0, 0, 0, 1);
`ifdef VIDEO_ROUTE_AUTO_REPAIR_EN
        add_vec("g3_mute",   g3, z,  1, 0, 0, 1);
        add_vec("g3_apply",  g3, mk(1, 0, 0, 0, 0, 0), 1, 1, 0, 1);
        add_vec("g3_drain",  g3, mk(1, 0, 0, 0, 0, 0), 1, 0, 0, 1);
        add_vec("g3_unmute", g3, mk(1, 0, 0, 0, 0, 0), 0, 0, 0, 0);
`else
        add_vec("g3_reject", g3, z,  0, 0, 1, 0);
        add_vec("g3_hold",   g3, z,  0, 0, 1, 0);
`endif

        // reset state while rst is held
        repeat (3) @(negedge clk_pixel);
        check_all("reset", z, 0, 0, 0, 0);
        rst = 1'b0;

        run_vectors(0, 9);

        // rejection must land within 30 cycles of entering CHECK
        waited = 0;
        while (cfg_busy && waited < 30) begin
            @(negedge clk_pixel);
            waited++;
        end
        check("g2_busy_drop", 18'(cfg_busy), 18'd0);
        $display("g2 busy dropped after %0d cycles", waited);

        run_vectors(10, 11);
        snap_mute = mute_cycles;
        run_vectors(12, 14);
        check("d1_no_mute", 18'(mute_cycles - snap_mute), 18'd0);

        // toggle the request on every frame strobe: never settles
        snap_apply = apply_cycles;
        req_vec = ca;
        gap();
        for (int i = 0; i < 6; i++) begin
            req_vec = (i % 2 == 0) ? cb : ca;
            strobe();
            $display("toggle %0d req=%h busy=%0b app=%h", i, req_vec, cfg_busy, app_vec);
            gap();
        end
        check("toggle.busy",  18'(cfg_busy), 18'd1);
        check("toggle.app",   app_vec, d1);
        check("toggle.apply", 18'(apply_cycles - snap_apply), 18'd0);
        check("toggle.mute",  18'(video_mute), 18'd0);

        // hold the last request: settles, checks, enters the mute
        strobe();
        check("hold.busy", 18'(cfg_busy), 18'd1);
        gap();
        strobe();
        check("hold.mute", 18'(video_mute), 18'd1);
        $display("hold mute=%0b app=%h", video_mute, app_vec);

        // reset while muted
        rst = 1'b1;
        @(negedge clk_pixel);
        check_all("rst_mute", z, 0, 0, 0, 0);
        $display("rst_mute app=%h mute=%0b busy=%0b", app_vec, video_mute, cfg_busy);
        rst = 1'b0;
        req_vec = z;

        run_vectors(15, vecs.size() - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
